// File: rtl/maj_sweep_pkg.sv
// Shared types and constants for the MAJ3 truth-table sweeper.
// Gate entry layout: {inv2,sel2,inv1,sel1,inv0,sel0}, operand 0 in the low bits.
package maj_sweep_pkg;

    localparam int unsigned NUM_IN    = 7;
    localparam int unsigned MAX_GATES = 16;
    localparam int unsigned SEL_W     = 5;
    localparam int unsigned TT_W      = 1 << NUM_IN;
    localparam int unsigned VEC_W     = NUM_IN;
    localparam int unsigned GIDX_W    = 4;
    localparam int unsigned NG_W      = 5;
    localparam int unsigned PROG_W    = 3 * (SEL_W + 1);

    typedef struct packed {
        logic             inv;
        logic [SEL_W-1:0] sel;
    } operand_t;

    typedef operand_t [2:0] gate_t;

    localparam logic [SEL_W-1:0] SEL_CONST0 = 5'd7;
    localparam logic [SEL_W-1:0] SEL_GATE0  = 5'd8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_EVAL  = 2'd1;
    localparam state_t ST_STORE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic logic num_gates_valid(input logic [NG_W-1:0] ng);
        return (ng != '0) && (ng <= NG_W'(MAX_GATES));
    endfunction

endpackage

// File: rtl/maj3_unit.sv
// Shared combinational majority-of-3 with per-operand inversion.
module maj3_unit (
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_c,
    input  logic [2:0] i_inv,
    output logic       o_maj
);

    logic w_a;
    logic w_b;
    logic w_c;

    assign w_a   = i_a ^ i_inv[0];
    assign w_b   = i_b ^ i_inv[1];
    assign w_c   = i_c ^ i_inv[2];
    assign o_maj = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);

endmodule

// File: rtl/maj_tt_sweeper.sv
// Sweeps all 2**NUM_IN input vectors through a programmed MAJ3 gate list, one gate per cycle.
// Optional TT_COMPARE_EN adds i_tt_exp / o_tt_match to compare the result with an expected table.
module maj_tt_sweeper
    import maj_sweep_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_prog_we,
    input  logic [GIDX_W-1:0] i_prog_addr,
    input  logic [PROG_W-1:0] i_prog_data,
    input  logic [NG_W-1:0]   i_num_gates,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
`ifdef TT_COMPARE_EN
    input  logic [TT_W-1:0]   i_tt_exp,
    output logic              o_tt_match,
`endif
    output logic [TT_W-1:0]   o_tt_out
);

    state_t               r_state;
    logic [VEC_W-1:0]     r_vec;
    logic [GIDX_W-1:0]    r_gate;
    logic [NG_W-1:0]      r_num;
    logic [MAX_GATES-1:0] r_result;
    logic [TT_W-1:0]      r_tt_out;
    logic                 r_err;
    gate_t                r_prog [MAX_GATES];

    logic                 w_busy;
    logic                 w_start_ok;
    logic                 w_prog_wr;
    logic [NG_W-1:0]      w_num_m1;
    logic [GIDX_W-1:0]    w_last_idx;
    logic                 w_gate_last;
    gate_t                w_gate;
    logic [2:0]           w_raw;
    logic [2:0]           w_inv;
    logic                 w_op_err;
    logic [SEL_W-1:0]     w_gidx [3];
    logic                 w_maj;

    assign w_busy      = (r_state == ST_EVAL) || (r_state == ST_STORE);
    assign w_start_ok  = (r_state == ST_IDLE) && i_start;
    assign w_prog_wr   = i_prog_we && !w_busy;
    assign w_num_m1    = r_num - 1'b1;
    assign w_last_idx  = w_num_m1[GIDX_W-1:0];
    assign w_gate_last = ({1'b0, r_gate} == w_num_m1);
    assign w_gate      = r_prog[r_gate];

    // Program RAM has no reset; writes are blocked during a sweep so the program stays stable.
    always_ff @(posedge i_clk) begin
        if (w_prog_wr) begin
            r_prog[i_prog_addr] <= gate_t'(i_prog_data);
        end
    end

    // Operand fetch: primary input, constant 0, or an earlier gate result. Forward, self and
    // out-of-range references read as 0 and raise the error flag.
    always_comb begin
        w_raw    = '0;
        w_inv    = '0;
        w_op_err = 1'b0;
        for (int k = 0; k < 3; k++) begin
            w_gidx[k] = w_gate[k].sel - SEL_GATE0;
            w_inv[k]  = w_gate[k].inv;
            if (w_gate[k].sel < SEL_CONST0) begin
                w_raw[k] = r_vec[w_gate[k].sel[2:0]];
            end else if (w_gate[k].sel >= SEL_GATE0) begin
                if (w_gidx[k] < {1'b0, r_gate}) begin
                    w_raw[k] = r_result[w_gidx[k][GIDX_W-1:0]];
                end else begin
                    w_op_err = 1'b1;
                end
            end
        end
    end

    maj3_unit u_maj3 (
        .i_a   (w_raw[0]),
        .i_b   (w_raw[1]),
        .i_c   (w_raw[2]),
        .i_inv (w_inv),
        .o_maj (w_maj)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_vec    <= '0;
            r_gate   <= '0;
            r_num    <= '0;
            r_result <= '0;
            r_tt_out <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_num    <= i_num_gates;
                        r_vec    <= '0;
                        r_gate   <= '0;
                        r_tt_out <= '0;
                        if (num_gates_valid(i_num_gates)) begin
                            r_err   <= 1'b0;
                            r_state <= ST_EVAL;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_EVAL: begin
                    r_result[r_gate] <= w_maj;
                    if (w_op_err) begin
                        r_err <= 1'b1;
                    end
                    if (w_gate_last) begin
                        r_state <= ST_STORE;
                    end else begin
                        r_gate <= r_gate + 1'b1;
                    end
                end
                ST_STORE: begin
                    r_tt_out[r_vec] <= r_result[w_last_idx];
                    if (r_vec == '1) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_vec   <= r_vec + 1'b1;
                        r_gate  <= '0;
                        r_state <= ST_EVAL;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TT_COMPARE_EN
    logic [TT_W-1:0] r_tt_exp;
    logic            r_match_vld;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tt_exp    <= '0;
            r_match_vld <= 1'b0;
        end else if (w_start_ok) begin
            r_tt_exp    <= i_tt_exp;
            r_match_vld <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_match_vld <= 1'b1;
        end
    end

    // Valid from the done cycle onward; the table is final once DONE is entered.
    assign o_tt_match = ((r_state == ST_DONE) || r_match_vld) && (r_tt_out == r_tt_exp);
`endif

    assign o_busy   = w_busy;
    assign o_done   = (r_state == ST_DONE);
    assign o_err    = r_err;
    assign o_tt_out = r_tt_out;

endmodule

// File: tb/tb_maj_tt_sweeper.sv
// Randomized and directed bench for maj_tt_sweeper against a vector-by-vector reference model.
module tb_maj_tt_sweeper;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         prog_we = 1'b0;
    logic [3:0]   prog_addr = '0;
    logic [17:0]  prog_data = '0;
    logic [4:0]   num_gates = '0;
    logic         start = 1'b0;
    logic         busy;
    logic         done;
    logic         err;
    logic [127:0] tt_out;
`ifdef TT_COMPARE_EN
    logic [127:0] tt_exp = '0;
    logic         tt_match;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int m_sel [16][3];
    int m_inv [16][3];

    always #5 clk = ~clk;

    maj_tt_sweeper dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_prog_we   (prog_we),
        .i_prog_addr (prog_addr),
        .i_prog_data (prog_data),
        .i_num_gates (num_gates),
        .i_start     (start),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
`ifdef TT_COMPARE_EN
        .i_tt_exp    (tt_exp),
        .o_tt_match  (tt_match),
`endif
        .o_tt_out    (tt_out)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] pack(input int s0, input int i0, input int s1, input int i1,
                                         input int s2, input int i2);
        logic [5:0] a, b, c;
        a = {i0[0], s0[4:0]};
        b = {i1[0], s1[4:0]};
        c = {i2[0], s2[4:0]};
        return {c, b, a};
    endfunction

    // Sets shadow program and drives the write signals; no clock edge consumed.
    task automatic set_gate(input int g, input int s0, input int i0, input int s1, input int i1,
                            input int s2, input int i2);
        m_sel[g][0] = s0; m_inv[g][0] = i0;
        m_sel[g][1] = s1; m_inv[g][1] = i1;
        m_sel[g][2] = s2; m_inv[g][2] = i2;
        prog_we   = 1'b1;
        prog_addr = g[3:0];
        prog_data = pack(s0, i0, s1, i1, s2, i2);
    endtask

    task automatic prog_gate(input int g, input int s0, input int i0, input int s1, input int i1,
                             input int s2, input int i2);
        set_gate(g, s0, i0, s1, i1, s2, i2);
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    // Reference: evaluate the network directly for every vector.
    task automatic model(input int g, output logic [127:0] tt, output logic e);
        int val [16];
        int b, s, sel;
        tt = '0;
        e  = (g < 1) || (g > 16);
        if (!e) begin
            for (int v = 0; v < 128; v++) begin
                for (int gi = 0; gi < g; gi++) begin
                    s = 0;
                    for (int k = 0; k < 3; k++) begin
                        sel = m_sel[gi][k];
                        if (sel < 7) b = (v >> sel) & 1;
                        else if (sel == 7) b = 0;
                        else if (sel - 8 < gi) b = val[sel - 8];
                        else begin
                            b = 0;
                            e = 1'b1;
                        end
                        s += b ^ m_inv[gi][k];
                    end
                    val[gi] = (s >= 2) ? 1 : 0;
                end
                tt[v] = (val[g - 1] != 0);
            end
        end
    endtask

    // poke_kind 1: extra start mid-sweep; 2: program write mid-sweep.
    task automatic sweep(input int ng, input int poke_cyc, input int poke_kind, output int cyc,
                         output logic [127:0] tt_d, output logic err_d, output logic busy1,
                         output logic match_d);
        start     = 1'b1;
        num_gates = ng[4:0];
        @(posedge clk); #1;
        start   = 1'b0;
        prog_we = 1'b0;
        cyc     = 1;
        busy1   = busy;
        while (!done && cyc < 2400) begin
            if (cyc == poke_cyc) begin
                if (poke_kind == 1) begin
                    start     = 1'b1;
                    num_gates = 5'd0;
                end else if (poke_kind == 2) begin
                    prog_we   = 1'b1;
                    prog_addr = 4'd0;
                    prog_data = pack(7, 1, 7, 1, 7, 1);
                end
            end
            @(posedge clk); #1;
            start   = 1'b0;
            prog_we = 1'b0;
            cyc++;
        end
        check_val("done_seen", done, 1'b1);
        tt_d    = tt_out;
        err_d   = err;
`ifdef TT_COMPARE_EN
        match_d = tt_match;
`else
        match_d = 1'b0;
`endif
        @(posedge clk); #1;
        check_val("done_pulse", done, 1'b0);
        check_val("busy_idle", busy, 1'b0);
    endtask

    task automatic run_and_check(input string tag, input int ng, input int poke_cyc,
                                 input int poke_kind, output logic [127:0] tt_got,
                                 output logic match_got);
        logic [127:0] exp_tt;
        logic         exp_err, err_got, busy1, bad;
        int           cyc, exp_cyc;
        model(ng, exp_tt, exp_err);
        bad     = (ng < 1) || (ng > 16);
        exp_cyc = bad ? 1 : 128 * (ng + 1) + 1;
        sweep(ng, poke_cyc, poke_kind, cyc, tt_got, err_got, busy1, match_got);
        check_val({tag, ".cycles"}, cyc, exp_cyc);
        check_val({tag, ".tt"}, tt_got, exp_tt);
        check_val({tag, ".err"}, err_got, exp_err);
        check_val({tag, ".busy1"}, busy1, !bad);
    endtask

    initial begin
        logic [127:0] tt;
        logic         m;
        int           g, kind, sel;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst.busy", busy, 1'b0);
        check_val("rst.done", done, 1'b0);
        check_val("rst.err", err, 1'b0);
        check_val("rst.tt", tt_out, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MAJ(x0,x1,x2)
        prog_gate(0, 0, 0, 1, 0, 2, 0);
`ifdef TT_COMPARE_EN
        tt_exp = {16{8'hE8}};
`endif
        run_and_check("maj012", 1, -1, 0, tt, m);
        check_val("maj012.const", tt, {16{8'hE8}});
`ifdef TT_COMPARE_EN
        check_val("maj012.match", m, 1'b1);
        tt_exp[5] = ~tt_exp[5];
        run_and_check("maj012b", 1, -1, 0, tt, m);
        check_val("maj012b.nomatch", m, 1'b0);
`endif

        prog_gate(0, 0, 0, 1, 0, 7, 0);
        run_and_check("and01", 1, -1, 0, tt, m);
        check_val("and01.const", tt, {16{8'h88}});
        prog_gate(0, 0, 0, 1, 0, 7, 1);
        run_and_check("or01", 1, -1, 0, tt, m);
        check_val("or01.const", tt, {16{8'hEE}});

        prog_gate(0, 0, 0, 1, 0, 7, 0);
        prog_gate(1, 8, 0, 2, 0, 7, 0);
        run_and_check("and012", 2, -1, 0, tt, m);
        check_val("and012.const", tt, {16{8'h80}});

        run_and_check("ng0", 0, -1, 0, tt, m);
        run_and_check("ng17", 17, -1, 0, tt, m);

        prog_gate(0, 8, 0, 0, 0, 1, 0);
        run_and_check("selfref", 1, -1, 0, tt, m);

        // Start while busy and program write while busy must both be ignored.
        prog_gate(0, 0, 0, 1, 0, 2, 0);
        run_and_check("start_busy", 1, 30, 1, tt, m);
        run_and_check("we_busy", 1, 50, 2, tt, m);
        run_and_check("we_busy_after", 1, -1, 0, tt, m);

        // Write and start in the same cycle: the sweep sees the new entry.
        prog_gate(0, 0, 0, 1, 0, 7, 0);
        set_gate(0, 0, 0, 1, 0, 2, 0);
        run_and_check("we_start", 1, -1, 0, tt, m);

        for (int r = 0; r < 6; r++) begin
            g = $urandom_range(1, 16);
            for (int gi = 0; gi < g; gi++) begin
                for (int k = 0; k < 3; k++) begin
                    kind = $urandom_range(0, 3);
                    if (kind < 2) sel = $urandom_range(0, 6);
                    else if (kind == 2) sel = 7;
                    else if (gi > 0) sel = 8 + $urandom_range(0, gi - 1);
                    else sel = $urandom_range(0, 7);
                    m_sel[gi][k] = sel;
                    m_inv[gi][k] = $urandom_range(0, 1);
                end
                if (r == 5 && gi == g - 1) begin
                    m_sel[gi][0] = (($urandom_range(0, 1)) != 0) ? 8 + gi : 31;
                    m_inv[gi][0] = 0;
                end
                prog_gate(gi, m_sel[gi][0], m_inv[gi][0], m_sel[gi][1], m_inv[gi][1],
                          m_sel[gi][2], m_inv[gi][2]);
            end
            run_and_check($sformatf("rand%0d", r), g, -1, 0, tt, m);
        end

        // Reset at cycle 100 of a sweep.
        prog_gate(0, 0, 0, 1, 0, 2, 0);
        start     = 1'b1;
        num_gates = 5'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        check_val("midrst.pre_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("midrst.busy", busy, 1'b0);
        check_val("midrst.tt", tt_out, '0);
        check_val("midrst.done", done, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_and_check("post_rst", 1, -1, 0, tt, m);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
